// File: rtl/onchip_audio_streamer_pkg.sv
// Shared definitions for the on-chip audio streamer.
//   SAMPLE_W : width of one L or R audio sample
//   WORD_W   : width of one stereo RAM word ({left, right})
//   state_e  : playback FSM states, also exported on the debug state port
package onchip_audio_streamer_pkg;

    localparam int SAMPLE_W = 16;
    localparam int WORD_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/onchip_audio_streamer_if.sv
// Bus bundle between the streamer, the sample RAM read port and the DAC stream.
//   mem_*     : Avalon-MM read port toward the RAM (readdata returns 1 cycle after chipselect)
//   out_*     : sample stream toward the DAC
// Stream handshake: a sample transfers on every rising edge where out_valid and
// out_ready are both high; while out_valid is high and out_ready is low the
// producer holds out_left/out_right stable and keeps out_valid high. out_ready
// may change freely and does not depend on out_valid.
// Modports: master = streamer side, slave = RAM/DAC side.
interface onchip_audio_streamer_if #(
    parameter int ADDR_W = 12
);
    import onchip_audio_streamer_pkg::*;

    logic [ADDR_W-1:0]   mem_address;
    logic                mem_chipselect;
    logic                mem_write;
    logic [3:0]          mem_byteenable;
    logic                mem_clken;
    logic [WORD_W-1:0]   mem_readdata;
    logic                out_valid;
    logic                out_ready;
    logic [SAMPLE_W-1:0] out_left;
    logic [SAMPLE_W-1:0] out_right;

    modport master (
        output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        input  mem_readdata,
        output out_valid, out_left, out_right,
        input  out_ready
    );

    modport slave (
        input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_clken,
        output mem_readdata,
        input  out_valid, out_left, out_right,
        output out_ready
    );

endinterface

// File: rtl/onchip_audio_streamer_fifo.sv
// Synchronous first-word-fall-through FIFO holding captured RAM words.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push/wdata : write a word (accepted when not full, or when full with a pop)
//   pop        : drop the head word (ignored when empty)
//   rdata      : current head word, valid whenever empty=0
//   count      : number of stored words (0..DEPTH)
//   full/empty : status flags
module onchip_audio_streamer_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Storage carries no reset; contents are meaningless once count is zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/onchip_audio_streamer.sv
// Avalon-MM read master that plays a window of stereo words from the on-chip
// sample RAM into the DAC stream, one-shot or looped.
//   clk, reset          : clock, asynchronous active-high reset
//   start/stop          : playback control pulses
//   base_addr/num_words : window start and length in words (latched on start)
//   loop_en             : replay the window until stop
//   busy/done           : playback active / one-cycle completion pulse
//   dbg_state           : current FSM state
//   bus (master)        : RAM read port and sample stream
module onchip_audio_streamer
    import onchip_audio_streamer_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DEPTH_WORDS = 3000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W-1:0]    num_words,
    input  logic                 loop_en,
    output logic                 busy,
    output logic                 done,
    output state_e               dbg_state,
    onchip_audio_streamer_if.master bus
);

    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_WORDS - 1);
    localparam logic [CNT_W:0]    CREDITS   = (CNT_W + 1)'(FIFO_DEPTH);

    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] num_q;
    logic              loop_q;
    logic [ADDR_W-1:0] wcnt_q;
    logic              rd_pending_q;

    logic              issue;
    logic              last_word;
    logic [CNT_W:0]    credit_used;

    logic [WORD_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;

    always_comb begin
        addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        last_word   = (wcnt_q == num_q - ADDR_W'(1));
        // Words already buffered plus the one read still returning from the RAM.
        credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending_q};
        // fifo_full is implied by the credit check; kept as an explicit guard.
        issue       = (state_q == ST_RUN) && !fifo_full && (credit_used < CREDITS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= '0;
            base_q       <= '0;
            num_q        <= '0;
            loop_q       <= 1'b0;
            wcnt_q       <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            // Every issued read returns exactly one cycle later and is always captured.
            rd_pending_q <= issue;
            case (state_q)
                ST_IDLE: begin
                    // stop in the same cycle suppresses the start.
                    if (start && !stop) begin
                        base_q <= base_addr;
                        num_q  <= num_words;
                        loop_q <= loop_en;
                        addr_q <= base_addr;
                        wcnt_q <= '0;
                        if (num_words == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (last_word) begin
                            // Looped pass end: jump straight back to the base, no idle cycle.
                            wcnt_q <= '0;
                            addr_q <= base_q;
                        end else begin
                            wcnt_q <= wcnt_q + ADDR_W'(1);
                            addr_q <= addr_d;
                        end
                    end
                    if (stop || (issue && last_word && !loop_q)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!rd_pending_q && fifo_empty) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_pop = bus.out_valid && bus.out_ready;

    onchip_audio_streamer_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_pending_q),
        .pop   (fifo_pop),
        .wdata (bus.mem_readdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

    assign bus.mem_address    = addr_q;
    assign bus.mem_chipselect = issue;
    assign bus.mem_write      = 1'b0;
    assign bus.mem_byteenable = 4'hF;
    assign bus.mem_clken      = 1'b1;

    assign bus.out_valid = !fifo_empty;
    assign bus.out_left  = fifo_rdata[WORD_W-1:SAMPLE_W];
    assign bus.out_right = fifo_rdata[SAMPLE_W-1:0];

endmodule

// File: tb/tb_onchip_audio_streamer.sv
module tb_onchip_audio_streamer;
    import onchip_audio_streamer_pkg::*;

    localparam int ADDR_W      = 12;
    localparam int DEPTH_WORDS = 3000;
    localparam int FIFO_DEPTH  = 4;

    // ---------------- clock / reset / DUT ----------------
    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] num_words;
    logic              loop_en;
    logic              busy;
    logic              done;
    state_e            dbg_state;

    onchip_audio_streamer_if #(.ADDR_W(ADDR_W)) bus ();

    onchip_audio_streamer #(
        .ADDR_W      (ADDR_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .base_addr (base_addr),
        .num_words (num_words),
        .loop_en   (loop_en),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- RAM and DAC models ----------------
    logic [31:0] ram [0:DEPTH_WORDS-1];

    always @(posedge clk) begin
        if (bus.mem_chipselect) bus.mem_readdata <= ram[bus.mem_address];
    end

    int ready_mode = 0;   // 0: always ready, 1: random, 2: held low
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 3) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the k-th word fetched in playback of window (base, num).
    function automatic int addr_at(input int base, input int num, input int k);
        return (base + (k % num)) % DEPTH_WORDS;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] issued_q[$];
    int cs_count, xfer_count, done_count, busy_seen;
    int first_valid_cyc, first_cs_cyc, last_cs_cyc, start_cyc;
    logic        prev_stall;
    logic [31:0] prev_data;

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.out_valid), 32'd1);
                check("hold_data", {bus.out_left, bus.out_right}, prev_data);
            end
            if (bus.mem_chipselect) begin
                issued_q.push_back(bus.mem_address);
                if (first_cs_cyc < 0) first_cs_cyc = cyc;
                last_cs_cyc = cyc;
                cs_count++;
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("extra_xfer", 32'd1, 32'd0);
                else check("data", {bus.out_left, bus.out_right}, exp_q.pop_front());
                xfer_count++;
            end
            if (done) done_count++;
            if (busy) busy_seen++;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = {bus.out_left, bus.out_right};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_sb();
        exp_q.delete();
        issued_q.delete();
        cs_count = 0; xfer_count = 0; done_count = 0; busy_seen = 0;
        first_valid_cyc = -1; first_cs_cyc = -1; last_cs_cyc = -1;
        prev_stall = 1'b0;
    endtask

    task automatic load_exp(input int base, input int num, input int passes);
        for (int k = 0; k < num * passes; k++) exp_q.push_back(ram[addr_at(base, num, k)]);
    endtask

    task automatic do_start(input int b, input int n, input logic l, input logic s);
        @(posedge clk); #1;
        base_addr = ADDR_W'(b);
        num_words = ADDR_W'(n);
        loop_en   = l;
        start     = 1'b1;
        stop      = s;
        start_cyc = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1;
        stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_count == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_count == 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_xfer(input int target, input int budget);
        int n;
        n = 0;
        while (xfer_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (xfer_count < target) check("xfer_timeout", 32'(xfer_count), 32'(target));
    endtask

    task automatic end_checks(input int base, input int num, input bit one_shot);
        repeat (4) @(negedge clk);
        check("done_count", 32'(done_count), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("state_end", 32'(dbg_state), 32'(ST_IDLE));
        check("xfer_vs_issue", 32'(xfer_count), 32'(cs_count));
        if (one_shot) check("n_issued", 32'(cs_count), 32'(num));
        foreach (issued_q[i]) check("addr", 32'(issued_q[i]), 32'(addr_at(base, num, i)));
    endtask

    task automatic fill_ram_random();
        for (int i = 0; i < DEPTH_WORDS; i++) ram[i] = $urandom;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int b, n, stopn;
        logic l;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        base_addr = '0; num_words = '0; loop_en = 1'b0;
        bus.out_ready = 1'b1;
        bus.mem_readdata = '0;
        for (int i = 0; i < DEPTH_WORDS; i++) ram[i] = i * 32'h0001_0001;
        clear_sb();
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cs", 32'(bus.mem_chipselect), 32'd0);
        check("rst_addr", 32'(bus.mem_address), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: basic one-shot, always ready
        clear_sb(); ready_mode = 0;
        load_exp(10, 4, 1);
        do_start(10, 4, 1'b0, 1'b0);
        wait_done(200);
        check("cs_latency", 32'(first_cs_cyc - start_cyc), 32'd0);
        check("cs_span", 32'(last_cs_cyc - first_cs_cyc), 32'd3);
        check("valid_latency", 32'(first_valid_cyc - start_cyc), 32'd2);
        end_checks(10, 4, 1'b1);

        // 2: downstream stalled, credit limit holds issue at FIFO_DEPTH
        clear_sb(); ready_mode = 2;
        load_exp(10, 8, 1);
        do_start(10, 8, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        check("stall_issued", 32'(cs_count), 32'(FIFO_DEPTH));
        check("stall_cs_low", 32'(bus.mem_chipselect), 32'd0);
        check("stall_xfer", 32'(xfer_count), 32'd0);
        ready_mode = 0;
        wait_done(200);
        end_checks(10, 8, 1'b1);

        // 3: address wrap at the top of the RAM
        fill_ram_random();
        clear_sb(); ready_mode = 1;
        load_exp(2998, 4, 1);
        do_start(2998, 4, 1'b0, 1'b0);
        wait_done(300);
        end_checks(2998, 4, 1'b1);

        // 4: looped playback, stopped after 8 transfers
        clear_sb(); ready_mode = 1;
        load_exp(5, 3, 20);
        do_start(5, 3, 1'b1, 1'b0);
        wait_xfer(8, 500);
        pulse_stop();
        wait_done(300);
        end_checks(5, 3, 1'b0);

        // 5: zero-length window, then start together with stop
        clear_sb(); ready_mode = 0;
        do_start(7, 0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("zero_done", 32'(done_count), 32'd1);
        check("zero_cs", 32'(cs_count), 32'd0);
        check("zero_busy", 32'(busy_seen), 32'd0);
        clear_sb();
        do_start(7, 4, 1'b0, 1'b1);
        repeat (6) @(negedge clk);
        check("ss_cs", 32'(cs_count), 32'd0);
        check("ss_done", 32'(done_count), 32'd0);
        check("ss_busy", 32'(busy_seen), 32'd0);
        check("ss_state", 32'(dbg_state), 32'(ST_IDLE));

        // randomized windows, one-shot and looped with random stop points
        for (int t = 0; t < 10; t++) begin
            fill_ram_random();
            clear_sb();
            ready_mode = (t % 2 == 0) ? 1 : 0;
            b = (t % 3 == 0) ? DEPTH_WORDS - int'($urandom_range(1, 6))
                             : int'($urandom_range(0, DEPTH_WORDS - 1));
            n = int'($urandom_range(1, 12));
            l = (t % 4 == 3);
            if (l) begin
                stopn = int'($urandom_range(2, 15));
                load_exp(b, n, 40);
                do_start(b, n, 1'b1, 1'b0);
                wait_xfer(stopn, 1000);
                pulse_stop();
                wait_done(500);
                end_checks(b, n, 1'b0);
            end else begin
                load_exp(b, n, 1);
                do_start(b, n, 1'b0, 1'b0);
                wait_done(1000);
                end_checks(b, n, 1'b1);
            end
        end

        // 6: reset mid-run with a read in flight, then replay from a new base
        clear_sb(); ready_mode = 2;
        do_start(100, 20, 1'b0, 1'b0);
        begin
            int w;
            w = 0;
            while (!bus.mem_chipselect && w < 50) begin
                @(negedge clk);
                w++;
            end
            check("mid_cs_seen", 32'(bus.mem_chipselect), 32'd1);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_cs", 32'(bus.mem_chipselect), 32'd0);
        check("mid_rst_addr", 32'(bus.mem_address), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        fill_ram_random();
        clear_sb(); ready_mode = 1;
        load_exp(2995, 9, 1);
        do_start(2995, 9, 1'b0, 1'b0);
        wait_done(500);
        end_checks(2995, 9, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
